// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port ALU arbiter: opcode set,
// FSM state encoding and the round-robin grant helper.
package alu_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int NUM_OPS = 14;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_XOR  = 5'd2,
    OP_OR   = 5'd3,
    OP_AND  = 5'd4,
    OP_SRL  = 5'd5,
    OP_SLL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_SLT  = 5'd8,
    OP_SLTU = 5'd9,
    OP_EQ   = 5'd10,
    OP_NE   = 5'd11,
    OP_GEU  = 5'd12,
    OP_LTU  = 5'd13
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // A lone requester always wins; on a tie the one not granted last wins.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] valid, input logic last);
    logic id;
    id = 1'b0;
    case (valid)
      2'b10:   id = 1'b1;
      2'b11:   id = ~last;
      default: id = 1'b0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU: 14 legal opcodes, anything else flags err and
// returns zero.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic [DATA_WIDTH-1:0]    srca,
  input  logic [DATA_WIDTH-1:0]    srcb,
  input  logic [OPCODE_LENGTH-1:0] op,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     err
);

  logic [31:0] op_wide;
  logic        legal;
  alu_op_e     op_e;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;
  logic        eq;

  assign op_wide = 32'(op);
  assign legal   = op_wide < 32'(NUM_OPS);
  assign op_e    = alu_op_e'(op_wide[4:0]);
  assign shamt   = srcb[4:0];
  assign lt_s    = $signed(srca) < $signed(srcb);
  assign lt_u    = srca < srcb;
  assign eq      = srca == srcb;

  always_comb begin
    result = '0;
    err    = ~legal;
    if (legal) begin
      case (op_e)
        OP_ADD:  result = srca + srcb;
        OP_SUB:  result = srca - srcb;
        OP_XOR:  result = srca ^ srcb;
        OP_OR:   result = srca | srcb;
        OP_AND:  result = srca & srcb;
        OP_SRL:  result = srca >> shamt;
        OP_SLL:  result = srca << shamt;
        OP_SRA:  result = $signed(srca) >>> shamt;
        // Compare results are zero-extended single-bit flags.
        OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
        OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
        OP_EQ:   result = {{(DATA_WIDTH-1){1'b0}}, eq};
        OP_NE:   result = {{(DATA_WIDTH-1){1'b0}}, ~eq};
        OP_GEU:  result = {{(DATA_WIDTH-1){1'b0}}, ~lt_u};
        OP_LTU:  result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end to a single ALU: round-robin grant in IDLE, one
// registered result held in RESP until its owner consumes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_srca,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_srcb,
  input  logic [NUM_REQ-1:0][OPCODE_LENGTH-1:0]  req_op,
  output logic [NUM_REQ-1:0]                     rsp_valid,
  input  logic [NUM_REQ-1:0]                     rsp_ready,
  output logic [DATA_WIDTH-1:0]                  rsp_data,
  output logic                                   rsp_err,
  output state_t                                 dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and
  // ready are both high at the same index. req_ready depends on req_valid
  // (the grant), never the reverse; rsp_valid holds with stable data until
  // rsp_ready at the owning index is seen high.

  state_t                  state_q;
  state_t                  next_state;
  logic                    grant_id;
  logic                    owner_q;
  logic                    last_q;
  logic                    accept;
  logic                    rsp_fire;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    alu_err;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    err_q;

  assign grant_id = rr_pick(req_valid, last_q);

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && (|req_valid) && !reset) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign accept   = |(req_valid & req_ready);
  assign rsp_fire = (state_q == RESP) && rsp_ready[owner_q];

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  alu #(
    .DATA_WIDTH    (DATA_WIDTH),
    .OPCODE_LENGTH (OPCODE_LENGTH)
  ) u_alu (
    .srca   (req_srca[grant_id]),
    .srcb   (req_srcb[grant_id]),
    .op     (req_op[grant_id]),
    .result (alu_result),
    .err    (alu_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= next_state;
    end
  end

  // A response handshake always returns to IDLE first, so back-to-back
  // operations are spaced at least two cycles apart.
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (accept) next_state = RESP;
      RESP:    if (rsp_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // last_q resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      owner_q <= grant_id;
      last_q  <= grant_id;
      data_q  <= alu_result;
      err_q   <= alu_err;
    end
  end

  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a cycle-level behavioural model checked
// every cycle, plus hand-computed expectations per scenario.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_srca;
  logic [1:0][31:0] req_srcb;
  logic [1:0][4:0]  req_op;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  state_t           dbg_state;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_srca  (req_srca),
    .req_srcb  (req_srcb),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy  = 1'b0;
  int          m_owner = 0;
  int          m_last  = 1;
  logic [31:0] m_data  = '0;
  bit          m_err   = 1'b0;
  logic [0:0]  exp_q[$];

  function automatic logic [31:0] model_alu(input int op, input logic [31:0] a,
                                            input logic [31:0] b, output bit err);
    int s;
    s   = int'(b[4:0]);
    err = 1'b0;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a ^ b;
      3:  return a | b;
      4:  return a & b;
      5:  return a >> s;
      6:  return a << s;
      7:  return a[31] ? ~((~a) >> s) : (a >> s);
      8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return (a == b) ? 32'd1 : 32'd0;
      11: return (a != b) ? 32'd1 : 32'd0;
      12: return (a >= b) ? 32'd1 : 32'd0;
      13: return (a < b) ? 32'd1 : 32'd0;
      default: begin
        err = 1'b1;
        return 32'd0;
      end
    endcase
  endfunction

  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return (last == 0) ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_last = 1;
      m_data = '0;
      m_err  = 1'b0;
    end else if (!m_busy) begin
      if (|req_valid) begin
        int g;
        g       = pick(req_valid, m_last);
        m_data  = model_alu(int'(req_op[g]), req_srca[g], req_srcb[g], m_err);
        m_owner = g;
        m_last  = g;
        m_busy  = 1'b1;
        exp_q.push_back(1'(g));
      end
    end else if (rsp_ready[m_owner]) begin
      m_busy = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [1:0] e_ready;
    logic [1:0] e_valid;
    e_ready = 2'b00;
    e_valid = 2'b00;
    if (!reset && !m_busy && (|req_valid)) e_ready[pick(req_valid, m_last)] = 1'b1;
    if (!reset && m_busy) e_valid[m_owner] = 1'b1;
    chk("cmp_req_ready", 32'(req_ready), 32'(e_ready));
    chk("cmp_rsp_valid", 32'(rsp_valid), 32'(e_valid));
    if (reset || (|e_valid)) begin
      chk("cmp_rsp_data", rsp_data, m_data);
      chk("cmp_rsp_err", 32'(rsp_err), 32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_one(input string name, input int p, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input logic exp_err);
    logic [1:0] onehot;
    onehot       = 2'b00;
    onehot[p]    = 1'b1;
    req_valid    = onehot;
    req_op[p]    = op;
    req_srca[p]  = a;
    req_srcb[p]  = b;
    @(negedge clk);
    chk({name, "_ready"}, 32'(req_ready), 32'(onehot));
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk({name, "_valid"}, 32'(rsp_valid), 32'(onehot));
    chk({name, "_data"}, rsp_data, exp_data);
    chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = onehot;
    step();
    rsp_ready = 2'b00;
  endtask

  // ---------------- directed scenarios ----------------
  logic [31:0] sweep_exp [14];
  bit          dummy_err;

  initial begin
    reset     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_srca  = '0;
    req_srcb  = '0;
    req_op    = '0;
    #1;
    do_reset();

    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    step();

    chk("model_sra", model_alu(7, 32'h8000_0000, 32'd4, dummy_err), 32'hF800_0000);
    chk("model_slt", model_alu(8, 32'hFFFF_FFFF, 32'd0, dummy_err), 32'd1);

    // Single requester ADD.
    run_one("add", 0, 5'd0, 32'd5, 32'd7, 32'd12, 1'b0);
    @(negedge clk);
    chk("add_done", 32'(rsp_valid), 32'd0);
    step();

    // Tie right after reset: port 0 first, port 1 next.
    do_reset();
    req_valid   = 2'b11;
    req_op[0]   = 5'd1;  req_srca[0] = 32'd10; req_srcb[0] = 32'd3;
    req_op[1]   = 5'd6;  req_srca[1] = 32'd1;  req_srcb[1] = 32'd4;
    @(negedge clk);
    chk("tie_ready0", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b10;
    @(negedge clk);
    chk("tie_resp_ready", 32'(req_ready), 32'b00);
    chk("tie_valid0", 32'(rsp_valid), 32'b01);
    chk("tie_data0", rsp_data, 32'd7);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("tie_ready1", 32'(req_ready), 32'b10);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("tie_valid1", 32'(rsp_valid), 32'b10);
    chk("tie_data1", rsp_data, 32'd16);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;

    // Continuous contention: strict alternation.
    exp_q.delete();
    req_op[0] = 5'd0; req_srca[0] = 32'd100; req_srcb[0] = 32'd1;
    req_op[1] = 5'd0; req_srca[1] = 32'd200; req_srcb[1] = 32'd2;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] g;
      g = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      chk("rr_ready", 32'(req_ready), 32'(g));
      step();
      @(negedge clk);
      chk("rr_valid", 32'(rsp_valid), 32'(g));
      chk("rr_data", rsp_data, (i % 2 == 0) ? 32'd101 : 32'd202);
      rsp_ready = 2'b11;
      step();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    chk("rr_count", 32'(exp_q.size()), 32'd6);
    for (int i = 0; i < 6 && exp_q.size() > 0; i++) begin
      chk("rr_order", 32'(exp_q.pop_front()), 32'(i % 2));
    end

    // Held response with back-pressure; port 0 waits and the owner-only
    // rsp_ready rule is exercised by asserting the wrong index.
    req_valid = 2'b10;
    req_op[1] = 5'd7; req_srca[1] = 32'h8000_0000; req_srcb[1] = 32'd4;
    @(negedge clk);
    chk("hold_ready", 32'(req_ready), 32'b10);
    step();
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'b10);
      chk("hold_data", rsp_data, 32'hF800_0000);
      chk("hold_req_ready", 32'(req_ready), 32'b00);
      chk("hold_state", 32'(dbg_state), 32'(RESP));
      step();
    end
    rsp_ready = 2'b10;
    req_valid = 2'b00;
    step();
    rsp_ready = 2'b00;

    // Unsupported opcodes.
    run_one("bad16", 0, 5'd16, 32'd123, 32'd456, 32'd0, 1'b1);
    run_one("bad31", 1, 5'd31, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);

    // Opcode sweep, A = F000000F, B = 4.
    sweep_exp = '{32'hF000_0013, 32'hF000_000B, 32'hF000_000B, 32'hF000_000F,
                  32'h0000_0004, 32'h0F00_0000, 32'h0000_00F0, 32'hFF00_0000,
                  32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0};
    for (int op = 0; op < 14; op++) begin
      run_one("sweep", op % 2, 5'(op), 32'hF000_000F, 32'd4, sweep_exp[op], 1'b0);
    end

    // Reset in the middle of a response discards it.
    req_valid = 2'b01;
    req_op[0] = 5'd0; req_srca[0] = 32'd1; req_srcb[0] = 32'd1;
    @(negedge clk);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("mid_valid", 32'(rsp_valid), 32'b01);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(rsp_valid), 32'd0);
    end
    step();
    req_valid = 2'b11;
    @(negedge clk);
    chk("post_rst_tie", 32'(req_ready), 32'b01);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("post_rst_rsp", 32'(rsp_valid), 32'b01);
    rsp_ready = 2'b11;
    step();
    rsp_ready = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 5, ALU operation code width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 2, per-requester request valid; index 0 = port 0, index 1 = port 1.
REQ-006 SHALL have port req_ready, output, 2, per-requester request accepted this cycle.
REQ-007 SHALL have port req_srca, input, 2 x DATA_WIDTH, per-requester operand A.
REQ-008 SHALL have port req_srcb, input, 2 x DATA_WIDTH, per-requester operand B.
REQ-009 SHALL have port req_op, input, 2 x OPCODE_LENGTH, per-requester ALU operation code.
REQ-010 SHALL have port rsp_valid, output, 2, per-requester result valid.
REQ-011 SHALL have port rsp_ready, input, 2, per-requester result consumed.
REQ-012 SHALL have port rsp_data, output, DATA_WIDTH, result shared by both requesters; meaningful only where rsp_valid is high.
REQ-013 SHALL have port rsp_err, output, 1, result is for an unsupported opcode.

Function
REQ-014 SHALL implement FSM states IDLE and RESP.
REQ-015 In IDLE, grant SHALL go to the single valid requester; with both valid, to the requester not granted last (round-robin).
REQ-016 In IDLE, req_ready SHALL be high only at the granted index; all-zero when no request; req_ready SHALL be low throughout RESP.
REQ-017 On handshake (req_valid and req_ready both high), the registers SHALL capture: granted id, ALU result of that requester's operands and opcode, error flag, and last-grant pointer; the FSM SHALL move to RESP.
REQ-018 Latency: rsp_valid[id] SHALL rise the cycle after acceptance; rsp_valid SHALL be one-hot or zero.
REQ-019 rsp_data, rsp_err and rsp_valid SHALL hold stable in RESP until rsp_ready[id] is high, then the FSM SHALL return to IDLE the next cycle; rsp_ready on the non-owning index SHALL be ignored.
REQ-020 Throughput SHALL be at most one operation per two cycles; no new request is accepted in the same cycle as a response handshake.
REQ-021 Opcodes 0-13 SHALL be supported with ALU semantics: ADD, SUB, XOR, OR, AND, SRL, SLL, SRA, SLT, SLTU, EQ, NE, GE (unsigned), LT (unsigned); shift amount is srcb[4:0].
REQ-022 Opcodes 14-31 SHALL produce rsp_err=1 and rsp_data=0 and complete the normal handshake.
REQ-023 Arithmetic SHALL wrap modulo 2^DATA_WIDTH; compare results SHALL be zero-extended 0/1.
REQ-024 A requester dropping req_valid before being granted SHALL lose nothing; requests are not queued internally.

Reset
REQ-025 Reset SHALL force IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, last-grant=1 (port 0 wins first tie).
REQ-026 Reset asserted in RESP SHALL discard the pending result; no rsp_valid SHALL appear after deassertion without a new request.

Structure
REQ-027 A shared package SHALL hold the opcode enum (14 legal codes), the FSM state typedef and the constant NUM_REQ=2.
REQ-028 Exactly one sub-module SHALL be instantiated: alu, fed by the grant-muxed operands and opcode; result register lives in alu_arbiter.

Verification
REQ-029 Port 0 alone, op ADD, A=5, B=7 -> req_ready[0] same cycle, rsp_valid[0] next cycle, rsp_data=12, rsp_err=0.
REQ-030 Both valid after reset, port 0 SUB 10-3, port 1 SLL 1<<4 -> port 0 granted first (7), port 1 granted next IDLE (16).
REQ-031 Both valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-032 Port 1 SRA A=0x80000000, B=4, rsp_ready held low 5 cycles -> rsp_valid[1] and rsp_data=0xF8000000 stable 5 cycles, req_ready=0 throughout.
REQ-033 Port 0 op 5'b10000 -> rsp_valid[0]=1, rsp_err=1, rsp_data=0.
REQ-034 Reset pulsed while in RESP -> rsp_valid=0 asynchronously; after release, next tie grants port 0.
